clk_cfg_seq: RTL and testbench

//  Sequencer that drives the clock-manager control inputs (sel_n_8mhz, sel_xclk, sel_rosc, clk_div).

---
 rtl/clk_cfg_seq_pkg.sv | 30 +++
 rtl/clk_cfg_seq_tgl_edge_sync.sv | 23 ++
 rtl/clk_cfg_seq.sv | 182 ++++++++++++++++++
 tb/tb_clk_cfg_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_cfg_seq_pkg.sv
// Shared types and constants for the clock-configuration sequencer.
package clk_cfg_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PARK   = 3'd1,
      ST_PROG   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_UNPARK = 3'd4,
      ST_RUN    = 3'd5,
      ST_FALLBK = 3'd6
   } state_t;

   typedef struct packed {
      logic       n_8mhz;
      logic       xclk;
      logic [1:0] rosc;
      logic [1:0] div;
   } cfg_t;

   localparam logic [1:0] SEL_ROSC_RST = 2'b11;
   localparam logic [1:0] CLK_DIV_RST  = 2'b00;

   localparam cfg_t CFG_RST = '{n_8mhz: 1'b0, xclk: 1'b0, rosc: SEL_ROSC_RST, div: CLK_DIV_RST};

   function automatic int cnt_width(input int a, input int b);
      return $clog2((a > b) ? a : b) + 1;
   endfunction

endpackage

// File: rtl/clk_cfg_seq_tgl_edge_sync.sv
// Brings the xclk/16 toggle into clk via two flops and pulses for one cycle on every change.
// Latency: 2-3 clk from toggle to pulse; no backpressure.
module tgl_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic tgl,
   output logic tgl_pls
);

   logic [2:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], tgl};
      end
   end

   // sync_q[2] is the previous synchronised value
   assign tgl_pls = sync_q[2] ^ sync_q[1];

endmodule

// File: rtl/clk_cfg_seq.sv
// Parks the clock manager on 8 MHz, reprograms it, qualifies xclk and unparks; monitors xclk in RUN.
// Latency: 2*SETTLE_CYC+2 to done (+CHK_WIN for xclk); req_ready only in IDLE/RUN.
module clk_cfg_seq
   import clk_cfg_seq_pkg::*;
#(
   parameter int SETTLE_CYC = 16,
   parameter int CHK_WIN    = 256,
   parameter int CHK_MIN    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_n_8mhz,
   input  logic       req_xclk,
   input  logic [1:0] req_rosc,
   input  logic [1:0] req_div,
   input  logic       xclk_tgl,
   output logic       sel_n_8mhz,
   output logic       sel_xclk,
   output logic [1:0] sel_rosc,
   output logic [1:0] clk_div,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic       xclk_lost
);

   localparam int CW = cnt_width(SETTLE_CYC, CHK_WIN);
   localparam int EW = $clog2(CHK_MIN + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] WIN_LAST    = CW'(CHK_WIN - 1);
   localparam logic [EW-1:0] EDGE_MIN    = EW'(CHK_MIN);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [EW-1:0] edge_cnt, edge_nxt, edge_sat;
   cfg_t          req_q, req_nxt;
   cfg_t          cfg_q, cfg_nxt;
   logic          fb_chk, fb_chk_nxt;
   logic          done_nxt, fail_nxt, lost_nxt, ready_nxt;
   logic          tgl_pls, settle_end, win_end, mon_fail, accept;
   cfg_t          req_in;

   tgl_edge_sync u_tgl_sync (
      .clk     (clk),
      .rst     (rst),
      .tgl     (xclk_tgl),
      .tgl_pls (tgl_pls)
   );

   assign req_in     = '{n_8mhz: req_n_8mhz, xclk: req_xclk, rosc: req_rosc, div: req_div};
   assign settle_end = (cnt == SETTLE_LAST);
   assign win_end    = (cnt == WIN_LAST);
   assign edge_sat   = (edge_cnt >= EDGE_MIN) ? EDGE_MIN : edge_cnt + EW'(tgl_pls);
   // Monitor failure takes priority over a request arriving in the same cycle
   assign mon_fail   = (state == ST_RUN) && cfg_q.xclk && cfg_q.n_8mhz && win_end &&
                       (edge_sat < EDGE_MIN);
   assign accept     = req_valid && req_ready && !mon_fail;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt + 1'b1;
      edge_nxt   = '0;
      req_nxt    = req_q;
      cfg_nxt    = cfg_q;
      fb_chk_nxt = fb_chk;
      done_nxt   = 1'b0;
      fail_nxt   = 1'b0;
      lost_nxt   = 1'b0;
      case (state)
         ST_IDLE, ST_RUN: begin
            if (mon_fail) begin
               state_nxt      = ST_FALLBK;
               cnt_nxt        = '0;
               cfg_nxt.xclk   = 1'b0;
               cfg_nxt.n_8mhz = 1'b0;
               fb_chk_nxt     = 1'b0;
               lost_nxt       = 1'b1;
            end else if (accept) begin
               state_nxt      = ST_PARK;
               cnt_nxt        = '0;
               req_nxt        = req_in;
               cfg_nxt.n_8mhz = 1'b0;
            end else if (state == ST_IDLE || win_end) begin
               cnt_nxt = '0;
            end else begin
               edge_nxt = edge_sat;
            end
         end
         ST_PARK: begin
            if (settle_end) begin
               state_nxt    = ST_PROG;
               cnt_nxt      = '0;
               cfg_nxt.xclk = req_q.xclk;
               cfg_nxt.rosc = req_q.rosc;
               cfg_nxt.div  = req_q.div;
            end
         end
         ST_PROG: begin
            if (settle_end) begin
               state_nxt = req_q.xclk ? ST_CHECK : ST_UNPARK;
               cnt_nxt   = '0;
            end
         end
         ST_CHECK: begin
            edge_nxt = edge_sat;
            if (win_end) begin
               cnt_nxt  = '0;
               edge_nxt = '0;
               if (edge_sat >= EDGE_MIN) begin
                  state_nxt = ST_UNPARK;
               end else begin
                  state_nxt      = ST_FALLBK;
                  cfg_nxt.xclk   = 1'b0;
                  cfg_nxt.n_8mhz = 1'b0;
                  fb_chk_nxt     = 1'b1;
               end
            end
         end
         ST_UNPARK: begin
            state_nxt      = ST_RUN;
            cnt_nxt        = '0;
            cfg_nxt.n_8mhz = req_q.n_8mhz;
            done_nxt       = 1'b1;
         end
         ST_FALLBK: begin
            if (settle_end) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               done_nxt  = fb_chk;
               fail_nxt  = fb_chk;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
      ready_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         edge_cnt  <= '0;
         req_q     <= CFG_RST;
         cfg_q     <= CFG_RST;
         fb_chk    <= 1'b0;
         req_ready <= 1'b0;
         busy      <= 1'b1;
         done      <= 1'b0;
         fail      <= 1'b0;
         xclk_lost <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         edge_cnt  <= edge_nxt;
         req_q     <= req_nxt;
         cfg_q     <= cfg_nxt;
         fb_chk    <= fb_chk_nxt;
         req_ready <= ready_nxt;
         busy      <= ~ready_nxt;
         done      <= done_nxt;
         fail      <= fail_nxt;
         xclk_lost <= lost_nxt;
      end
   end

   assign sel_n_8mhz = cfg_q.n_8mhz;
   assign sel_xclk   = cfg_q.xclk;
   assign sel_rosc   = cfg_q.rosc;
   assign clk_div    = cfg_q.div;

endmodule

// File: tb/tb_clk_cfg_seq.sv
// Scoreboard bench for clk_cfg_seq: expected completions queued at request time, checked at done.
module tb_clk_cfg_seq;

   localparam int S = 16;
   localparam int W = 256;
   localparam int LAT_ROSC = 2 * S + 2;
   localparam int LAT_XOK  = 2 * S + 2 + W;
   localparam int LAT_XBAD = 3 * S + W + 1;
   localparam logic [10:0] RST_VEC = 11'b0_0_11_00_0_1_000;

   typedef struct {
      int         lat;
      logic       fl;
      logic       n8;
      logic       x;
      logic [1:0] r;
      logic [1:0] d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_n_8mhz = 1'b0;
   logic       req_xclk = 1'b0;
   logic [1:0] req_rosc = 2'b00;
   logic [1:0] req_div = 2'b00;
   logic       xclk_tgl;
   logic       sel_n_8mhz, sel_xclk, busy, done, fail, xclk_lost;
   logic [1:0] sel_rosc, clk_div;

   logic       tgl_en = 1'b0;
   int         n_chk = 0;
   int         n_err = 0;
   int         cyc = 0;
   exp_t       sb_q[$];

   clk_cfg_seq #(.SETTLE_CYC(S), .CHK_WIN(W), .CHK_MIN(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_n_8mhz (req_n_8mhz),
      .req_xclk   (req_xclk),
      .req_rosc   (req_rosc),
      .req_div    (req_div),
      .xclk_tgl   (xclk_tgl),
      .sel_n_8mhz (sel_n_8mhz),
      .sel_xclk   (sel_xclk),
      .sel_rosc   (sel_rosc),
      .clk_div    (clk_div),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .xclk_lost  (xclk_lost)
   );

   always #5 clk = ~clk;

   // xclk/16 stand-in: toggles every 8 clk while enabled
   initial begin
      xclk_tgl = 1'b0;
      forever begin
         repeat (8) @(posedge clk);
         #2;
         if (tgl_en) xclk_tgl = ~xclk_tgl;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic issue_req(input logic n8, input logic x, input logic [1:0] r, input logic [1:0] d,
                            input int lat, input logic fl);
      exp_t e;
      int   t;
      t = 0;
      while (!req_ready && t < 2000) begin
         step();
         t++;
      end
      n_chk++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
      end
      req_valid  = 1'b1;
      req_n_8mhz = n8;
      req_xclk   = x;
      req_rosc   = r;
      req_div    = d;
      e.lat = lat;
      e.fl  = fl;
      e.n8  = fl ? 1'b0 : n8;
      e.x   = fl ? 1'b0 : x;
      e.r   = r;
      e.d   = d;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      cyc = 1;
   endtask

   task automatic wait_done();
      exp_t e;
      bit   seen;
      n_chk++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_empty: queue size=0 required >0");
      end else begin
         e = sb_q.pop_front();
         seen = 0;
         for (int i = 0; i < e.lat + 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1;
            else step();
         end
         if (!seen) begin
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles", e.lat + 40);
         end else begin
            n_chk++;
            if (cyc !== e.lat) begin
               n_err++;
               $display("FAIL done_latency: cycle=%0d required %0d", cyc, e.lat);
            end
            n_chk++;
            if ({fail, sel_n_8mhz, sel_xclk, sel_rosc, clk_div} !== {e.fl, e.n8, e.x, e.r, e.d}) begin
               n_err++;
               $display("FAIL done_cfg: fail/n8/x/rosc/div=%b/%b/%b/%b/%b required %b/%b/%b/%b/%b",
                        fail, sel_n_8mhz, sel_xclk, sel_rosc, clk_div, e.fl, e.n8, e.x, e.r, e.d);
            end
            n_chk++;
            if ({req_ready, busy} !== 2'b10) begin
               n_err++;
               $display("FAIL done_ready: ready/busy=%b%b required 10", req_ready, busy);
            end
            step();
            n_chk++;
            if ({done, fail} !== 2'b00) begin
               n_err++;
               $display("FAIL done_pulse: done/fail=%b%b one cycle later required 00", done, fail);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      n_chk++;
      if ({sel_n_8mhz, sel_xclk, sel_rosc, clk_div, req_ready, busy, done, fail, xclk_lost} !== RST_VEC) begin
         n_err++;
         $display("FAIL reset_vals: outputs=%b required %b",
                  {sel_n_8mhz, sel_xclk, sel_rosc, clk_div, req_ready, busy, done, fail, xclk_lost}, RST_VEC);
      end
      rst = 1'b0;
      step();
      n_chk++;
      if ({req_ready, busy} !== 2'b10) begin
         n_err++;
         $display("FAIL reset_ready: ready/busy=%b%b required 10", req_ready, busy);
      end
   endtask

   task automatic test_rosc();
      issue_req(1'b1, 1'b0, 2'b01, 2'b10, LAT_ROSC, 1'b0);
      while (cyc < 10) step();
      n_chk++;
      if ({sel_n_8mhz, sel_rosc, clk_div, busy, req_ready} !== {1'b0, 2'b11, 2'b00, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL rosc_park: n8/rosc/div/busy/ready=%b/%b/%b/%b/%b required 0/11/00/1/0",
                  sel_n_8mhz, sel_rosc, clk_div, busy, req_ready);
      end
      while (cyc < 25) step();
      n_chk++;
      if ({sel_n_8mhz, sel_rosc, clk_div} !== {1'b0, 2'b01, 2'b10}) begin
         n_err++;
         $display("FAIL rosc_prog: n8/rosc/div=%b/%b/%b required 0/01/10", sel_n_8mhz, sel_rosc, clk_div);
      end
      wait_done();
   endtask

   task automatic test_back_to_back();
      issue_req(1'b1, 1'b0, 2'b01, 2'b10, LAT_ROSC, 1'b0);
      wait_done();
      issue_req(1'b1, 1'b0, 2'b01, 2'b10, LAT_ROSC, 1'b0);
      wait_done();
   endtask

   task automatic test_xclk_pass();
      tgl_en = 1'b1;
      issue_req(1'b1, 1'b1, 2'b00, 2'b01, LAT_XOK, 1'b0);
      while (cyc < 100) step();
      n_chk++;
      if ({sel_n_8mhz, sel_xclk, busy} !== 3'b011) begin
         n_err++;
         $display("FAIL xclk_check: n8/x/busy=%b%b%b required 011", sel_n_8mhz, sel_xclk, busy);
      end
      wait_done();
   endtask

   task automatic test_xclk_lost();
      bit seen_lost;
      bit seen_done;
      seen_lost = 0;
      seen_done = 0;
      repeat (W) step();
      n_chk++;
      if ({xclk_lost, sel_n_8mhz, sel_xclk} !== 3'b011) begin
         n_err++;
         $display("FAIL live_ok: lost/n8/x=%b%b%b required 011", xclk_lost, sel_n_8mhz, sel_xclk);
      end
      tgl_en = 1'b0;
      for (int i = 0; i < 2 * W && !seen_lost; i++) begin
         step();
         if (done === 1'b1) seen_done = 1;
         if (xclk_lost === 1'b1) seen_lost = 1;
      end
      n_chk++;
      if (!seen_lost) begin
         n_err++;
         $display("FAIL lost_timeout: no xclk_lost within %0d cycles", 2 * W);
      end else begin
         n_chk++;
         if ({sel_n_8mhz, sel_xclk, req_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL lost_fallback: n8/x/ready=%b%b%b required 000", sel_n_8mhz, sel_xclk, req_ready);
         end
         step();
         n_chk++;
         if (xclk_lost !== 1'b0) begin
            n_err++;
            $display("FAIL lost_pulse: xclk_lost=%b one cycle later required 0", xclk_lost);
         end
         for (int i = 0; i < S + 4; i++) begin
            step();
            if (done === 1'b1) seen_done = 1;
         end
         n_chk++;
         if ({req_ready, sel_rosc, clk_div} !== {1'b1, 2'b00, 2'b01}) begin
            n_err++;
            $display("FAIL lost_idle: ready/rosc/div=%b/%b/%b required 1/00/01", req_ready, sel_rosc, clk_div);
         end
      end
      n_chk++;
      if (seen_done) begin
         n_err++;
         $display("FAIL lost_done: done seen=1 required 0");
      end
   endtask

   task automatic test_xclk_fail();
      tgl_en = 1'b0;
      issue_req(1'b1, 1'b1, 2'b01, 2'b11, LAT_XBAD, 1'b1);
      wait_done();
   endtask

   task automatic test_rst_mid();
      tgl_en = 1'b1;
      issue_req(1'b1, 1'b1, 2'b10, 2'b01, LAT_XOK, 1'b0);
      while (cyc < 60) step();
      rst = 1'b1;
      step();
      sb_q.delete();
      n_chk++;
      if ({sel_n_8mhz, sel_xclk, sel_rosc, clk_div, req_ready, busy, done, fail, xclk_lost} !== RST_VEC) begin
         n_err++;
         $display("FAIL rst_mid_vals: outputs=%b required %b",
                  {sel_n_8mhz, sel_xclk, sel_rosc, clk_div, req_ready, busy, done, fail, xclk_lost}, RST_VEC);
      end
      rst = 1'b0;
      step();
      tgl_en = 1'b0;
      issue_req(1'b0, 1'b0, 2'b10, 2'b01, LAT_ROSC, 1'b0);
      wait_done();
   endtask

   initial begin
      test_reset();
      test_rosc();
      test_back_to_back();
      test_xclk_pass();
      test_xclk_lost();
      test_xclk_fail();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
